// File: rtl/encoder_pkg.sv
// Shared constants for the quadrature encoder front end and encoder_core:
// default widths, Gray-code state encoding and the saturating error-count step.
package encoder_pkg;

  localparam int ENC_SYNC_STAGES_DEF = 2;
  localparam int ENC_FILT_W_DEF      = 8;
  localparam int ENC_ERR_CNT_W       = 16;

  // Quadrature states in forward rotation order, as {A, B}.
  typedef enum logic [1:0] {
    QUAD_S0 = 2'b00,
    QUAD_S1 = 2'b01,
    QUAD_S2 = 2'b11,
    QUAD_S3 = 2'b10
  } quad_state_e;

  // A new illegal event outranks a clear, so set-and-clear leaves a count of one.
  function automatic logic [ENC_ERR_CNT_W-1:0] err_cnt_next(
    input logic [ENC_ERR_CNT_W-1:0] cnt,
    input logic                     set,
    input logic                     clr
  );
    logic [ENC_ERR_CNT_W-1:0] base;
    base = clr ? '0 : cnt;
    if (set && (base != {ENC_ERR_CNT_W{1'b1}})) begin
      base = base + ENC_ERR_CNT_W'(1);
    end
    return base;
  endfunction

endpackage

// File: rtl/enc_debounce_chan.sv
// One encoder channel: pin synchroniser followed by a stability counter that
// only lets a level change through after it has persisted for filt_len cycles.
module enc_debounce_chan
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES = ENC_SYNC_STAGES_DEF,
  parameter int FILT_W      = ENC_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              raw,
  input  logic [FILT_W-1:0] filt_len,
  output logic              enc,
  output logic              acc
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   enc_q, enc_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  // The compare is >= so the counter tops out at filt_len and never wraps,
  // and lowering filt_len mid-count accepts on the next cycle.
  always_comb begin
    cnt_d = cnt_q;
    enc_d = enc_q;
    acc   = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (s == enc_q) begin
      cnt_d = '0;
    end else if (cnt_q < filt_len) begin
      cnt_d = cnt_q + FILT_W'(1);
    end else begin
      enc_d = s;
      cnt_d = '0;
      acc   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      enc_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      enc_q  <= enc_d;
    end
  end

  assign enc = enc_q;

endmodule

// File: rtl/encoder_input_filter.sv
// Quadrature input front end: synchronised, glitch-filtered A/B with an edge strobe
// and sticky illegal-transition flag. Define ENC_FILT_ERR_CNT_EN to add err_count.
module encoder_input_filter
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES = ENC_SYNC_STAGES_DEF,
  parameter int FILT_W      = ENC_FILT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              enc_a_raw,
  input  logic              enc_b_raw,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              err_clear,
  output logic              enc_a,
  output logic              enc_b,
  output logic              edge_strobe,
  output logic              err_illegal
`ifdef ENC_FILT_ERR_CNT_EN
  ,
  output logic [ENC_ERR_CNT_W-1:0] err_count
`endif
);

  logic acc_a, acc_b;
  logic acc_a_q, acc_a_d;
  logic acc_b_q, acc_b_d;
  logic strobe_q, strobe_d;
  logic err_q, err_d;
  logic illegal;

  enc_debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_W     (FILT_W)
  ) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .raw     (enc_a_raw),
    .filt_len(filt_len),
    .enc     (enc_a),
    .acc     (acc_a)
  );

  enc_debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_W     (FILT_W)
  ) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .raw     (enc_b_raw),
    .filt_len(filt_len),
    .enc     (enc_b),
    .acc     (acc_b)
  );

  // Accept pulses are held one cycle so the strobe lands in the cycle after
  // the filtered outputs change; both accepting together is a Gray-code violation.
  assign illegal = acc_a_q & acc_b_q;

  always_comb begin
    acc_a_d  = acc_a;
    acc_b_d  = acc_b;
    strobe_d = enable & (acc_a_q | acc_b_q);
    err_d    = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_a_q  <= 1'b0;
      acc_b_q  <= 1'b0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign edge_strobe = strobe_q;
  assign err_illegal = err_q;

`ifdef ENC_FILT_ERR_CNT_EN
  logic [ENC_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_next(err_cnt_q, illegal, err_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_encoder_input_filter.sv
// Directed bench for encoder_input_filter: vector table for pass-through and the
// forward Gray sequence, hand sequences for glitch, illegal, enable and reset cases.
module tb_encoder_input_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       enc_a_raw;
  logic       enc_b_raw;
  logic [7:0] filt_len;
  logic       err_clear;
  logic       enc_a;
  logic       enc_b;
  logic       edge_strobe;
  logic       err_illegal;
`ifdef ENC_FILT_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_input_filter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .enc_a_raw  (enc_a_raw),
    .enc_b_raw  (enc_b_raw),
    .filt_len   (filt_len),
    .err_clear  (err_clear),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .edge_strobe(edge_strobe),
    .err_illegal(err_illegal)
`ifdef ENC_FILT_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] filt;
    int         wait_cyc;
    logic       exp_a;
    logic       exp_b;
    logic       exp_strobe;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic b, input logic [7:0] f, input int w,
                              input logic ea, input logic eb, input logic es, input logic ee);
    vec_t v;
    v.a = a; v.b = b; v.filt = f; v.wait_cyc = w;
    v.exp_a = ea; v.exp_b = eb; v.exp_strobe = es; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    logic seen_bad;

    // Pass-through, filt_len=0: A rises, then returns to 0.
    vecs.push_back(mk(1, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4, 0, 0, 0, 0));
    // Forward sequence 00->01->11->10->00, filt_len=3: output 6 cycles after pin, strobe at 7.
    vecs.push_back(mk(0, 1, 3, 5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 3, 3, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 5, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 3, 3, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 3, 5, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 3, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3, 3, 0, 0, 0, 0));

    // Reset with pins high.
    reset = 1; enable = 1; enc_a_raw = 1; enc_b_raw = 1; filt_len = 0; err_clear = 0;
    tick(2);
    chk("reset_enc_a", 16'(enc_a), 16'h0);
    chk("reset_enc_b", 16'(enc_b), 16'h0);
    chk("reset_strobe", 16'(edge_strobe), 16'h0);
    chk("reset_err", 16'(err_illegal), 16'h0);
`ifdef ENC_FILT_ERR_CNT_EN
    chk("reset_err_count", err_count, 16'h0);
`endif
    enc_a_raw = 0; enc_b_raw = 0; reset = 0;
    tick(4);
    chk("idle_enc_a", 16'(enc_a), 16'h0);
    chk("idle_strobe", 16'(edge_strobe), 16'h0);

    foreach (vecs[i]) begin
      enc_a_raw = vecs[i].a;
      enc_b_raw = vecs[i].b;
      filt_len  = vecs[i].filt;
      tick(vecs[i].wait_cyc);
      chk($sformatf("vec%0d_enc_a", i), 16'(enc_a), 16'(vecs[i].exp_a));
      chk($sformatf("vec%0d_enc_b", i), 16'(enc_b), 16'(vecs[i].exp_b));
      chk($sformatf("vec%0d_strobe", i), 16'(edge_strobe), 16'(vecs[i].exp_strobe));
      chk($sformatf("vec%0d_err", i), 16'(err_illegal), 16'(vecs[i].exp_err));
    end

    // Glitch of exactly filt_len cycles must not propagate.
    filt_len = 4;
    enc_a_raw = 1;
    seen_bad = 0;
    repeat (4) begin
      tick(1);
      if (enc_a !== 1'b0 || edge_strobe !== 1'b0) seen_bad = 1;
    end
    enc_a_raw = 0;
    repeat (10) begin
      tick(1);
      if (enc_a !== 1'b0 || edge_strobe !== 1'b0) seen_bad = 1;
    end
    chk("glitch4_rejected", 16'(seen_bad), 16'h0);
    // Six-cycle pulse is accepted 2+4+1 cycles after the rising edge.
    enc_a_raw = 1;
    tick(6);
    chk("accept_filt4_cyc6", 16'(enc_a), 16'h0);
    tick(1);
    chk("accept_filt4_cyc7", 16'(enc_a), 16'h1);
    tick(1);
    chk("accept_filt4_strobe", 16'(edge_strobe), 16'h1);
    filt_len = 0;
    enc_a_raw = 0;
    tick(6);
    chk("return_a_low", 16'(enc_a), 16'h0);

    // Illegal 00->11 with filt_len=2.
    filt_len = 2;
    enc_a_raw = 1; enc_b_raw = 1;
    tick(4);
    chk("illegal_cyc4_ab", {14'h0, enc_a, enc_b}, 16'h0);
    tick(1);
    chk("illegal_cyc5_ab", {14'h0, enc_a, enc_b}, 16'h3);
    tick(1);
    chk("illegal_err_set", 16'(err_illegal), 16'h1);
    chk("illegal_strobe", 16'(edge_strobe), 16'h1);
`ifdef ENC_FILT_ERR_CNT_EN
    chk("illegal_count1", err_count, 16'h1);
`endif
    tick(2);
    chk("illegal_strobe_single", 16'(edge_strobe), 16'h0);
    chk("illegal_err_sticky", 16'(err_illegal), 16'h1);
    err_clear = 1;
    tick(1);
    err_clear = 0;
    chk("err_cleared", 16'(err_illegal), 16'h0);
`ifdef ENC_FILT_ERR_CNT_EN
    chk("count_cleared", err_count, 16'h0);
`endif
    // Second illegal (11->00) with err_clear on the same edge that sets the flag.
    enc_a_raw = 0; enc_b_raw = 0;
    tick(5);
    chk("illegal2_ab", {14'h0, enc_a, enc_b}, 16'h0);
    err_clear = 1;
    tick(1);
    err_clear = 0;
    chk("set_wins_over_clear", 16'(err_illegal), 16'h1);
`ifdef ENC_FILT_ERR_CNT_EN
    chk("count_set_and_clear", err_count, 16'h1);
`endif

    // Enable low: B toggles, outputs frozen, error flag holds.
    tick(3);
    enable = 0;
    seen_bad = 0;
    for (int i = 0; i < 20; i++) begin
      enc_b_raw = ~enc_b_raw;
      tick(1);
      if (enc_b !== 1'b0 || edge_strobe !== 1'b0) seen_bad = 1;
    end
    chk("disabled_frozen", 16'(seen_bad), 16'h0);
    enc_b_raw = 1;
    tick(4);
    chk("disabled_b_still_0", 16'(enc_b), 16'h0);
    chk("disabled_err_holds", 16'(err_illegal), 16'h1);
    enable = 1;
    tick(2);
    chk("enable_b_cyc2", 16'(enc_b), 16'h0);
    tick(1);
    chk("enable_b_cyc3", 16'(enc_b), 16'h1);
    tick(1);
    chk("enable_b_strobe", 16'(edge_strobe), 16'h1);
    chk("enable_no_new_illegal", {14'h0, enc_a, enc_b}, 16'h1);

    // Reset mid-debounce discards the pending count.
    tick(3);
    filt_len = 4;
    enc_a_raw = 1;
    tick(4);
    reset = 1;
    enc_b_raw = 0;
    tick(1);
    reset = 0;
    chk("midreset_ab", {14'h0, enc_a, enc_b}, 16'h0);
    chk("midreset_err", 16'(err_illegal), 16'h0);
    seen_bad = 0;
    repeat (6) begin
      tick(1);
      if (enc_a !== 1'b0 || edge_strobe !== 1'b0) seen_bad = 1;
    end
    chk("midreset_no_early_accept", 16'(seen_bad), 16'h0);
    tick(1);
    chk("midreset_full_latency", 16'(enc_a), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
